// File: rtl/limit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : limit_counter
//  Description : Start/pause/acknowledge up-counter. An accepted start captures
//                a terminal value and counts up from zero to it, then waits in
//                DONE for an acknowledge before returning to IDLE.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    rst    in   1      synchronous active-high reset
//    start  in   1      begin a run (looked at only in IDLE)
//    limit  in   WIDTH  terminal value, captured when start is accepted
//    pause  in   1      freeze counting while high in COUNT
//    ack    in   1      release DONE (looked at only in DONE)
//    count  out  WIDTH  current count value (registered)
//    busy   out  1      high exactly while in COUNT (registered)
//    done   out  1      high exactly while in DONE (registered)
// ============================================================================
module limit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_COUNT = 2'd1;
    localparam logic [1:0]       c_DONE  = 2'd2;
    localparam logic [WIDTH-1:0] c_ZERO  = '0;
    localparam logic [WIDTH-1:0] c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_count_inc;

    // In COUNT the count is always strictly below r_lim, so this increment
    // can never wrap; the run stops on the edge it equals r_lim.
    assign w_count_inc = r_count + c_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_lim   <= c_ZERO;
            r_count <= c_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_count <= c_ZERO;
                    if (start) begin
                        r_lim <= limit;
                        // A zero limit has nothing to count: go straight to DONE.
                        if (limit != c_ZERO) begin
                            r_state <= c_COUNT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_COUNT: begin
                    if (!pause) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_lim) begin
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    // start in the acknowledging cycle is ignored: it is only
                    // looked at from IDLE, which is entered on this edge.
                    if (ack) begin
                        r_state <= c_IDLE;
                        r_count <= c_ZERO;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_count <= c_ZERO;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire
